// File: rtl/instr_prefetch_queue.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// instr_prefetch_queue
//
// Instruction prefetch buffer between instruction memory and the IF stage.
// Issues sequential fetch requests over a req/ack handshake (one request
// outstanding at most), buffers returned words with their PCs in a circular
// FIFO, and hands them to IF over valid/ready. A taken branch (redirect_i)
// flushes the FIFO and restarts fetching at redirect_pc_i.
//
// Ports:
//   clk_i, rst_i         clock, asynchronous active-low reset
//   start_i              fetch enable; gates new requests only
//   redirect_i           flush and restart at redirect_pc_i
//   redirect_pc_i        restart address
//   mem_req_o/addr_o     fetch request and its (registered, stable) address
//   mem_ack_i/rdata_i    memory response
//   instr_valid_o        head entry valid
//   instr_o / pc_o       head instruction and its PC
//   instr_ready_i        IF consumes the head
//   count_o              FIFO occupancy
//
// Optional build macro: PREFETCH_BYPASS_EN
//   When defined, a word arriving while the FIFO is empty is presented to IF
//   in the same cycle; if IF takes it, it is never written into the FIFO.
//
// State | meaning
// IDLE  | no request outstanding
// REQ   | request outstanding, response will be pushed
// DRAIN | request outstanding after a redirect, response will be dropped
// ---------------------------------------------------------------------------
module instr_prefetch_queue #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned INSTR_LEN = 4,
  parameter logic [31:0] RESET_PC  = 32'h0
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic                     redirect_i,
  input  logic [31:0]              redirect_pc_i,
  output logic                     mem_req_o,
  output logic [31:0]              mem_addr_o,
  input  logic                     mem_ack_i,
  input  logic [31:0]              mem_rdata_i,
  output logic                     instr_valid_o,
  output logic [31:0]              instr_o,
  output logic [31:0]              pc_o,
  input  logic                     instr_ready_i,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int          AW     = $clog2(DEPTH);
  localparam int          CW     = AW + 1;
  localparam logic [31:0] PC_INC = 32'(INSTR_LEN);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [31:0]    fetch_pc_q, fetch_pc_d;
  logic [31:0]    addr_q, addr_d;
  logic [CW-1:0]  count_q, count_d;
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [31:0]    pc_mem_q    [DEPTH];
  logic [31:0]    instr_mem_q [DEPTH];

  logic           fifo_valid;
  logic           ack_ok;
  logic           push;
  logic           pop;
  logic [CW-1:0]  cnt_after;
  logic           space_ok;

  assign fifo_valid = (count_q != '0);
  assign ack_ok     = (state_q == REQ) && mem_ack_i;
  assign pop        = fifo_valid && instr_ready_i;

`ifdef PREFETCH_BYPASS_EN
  logic bypass;
  logic bypass_take;

  // Word arriving into an empty FIFO is forwarded straight to IF.
  assign bypass        = ack_ok && !redirect_i && !fifo_valid;
  assign bypass_take   = bypass && instr_ready_i;
  assign push          = ack_ok && !redirect_i && !bypass_take;
  assign instr_valid_o = fifo_valid || bypass;
  assign instr_o       = bypass ? mem_rdata_i : instr_mem_q[rd_ptr_q];
  assign pc_o          = bypass ? addr_q      : pc_mem_q[rd_ptr_q];
`else
  assign push          = ack_ok && !redirect_i;
  assign instr_valid_o = fifo_valid;
  assign instr_o       = instr_mem_q[rd_ptr_q];
  assign pc_o          = pc_mem_q[rd_ptr_q];
`endif

  // Occupancy after this cycle's push/pop; a new request is allowed only if
  // this leaves room, so the eventual response can always be stored.
  assign cnt_after = count_q + CW'(push) - CW'(pop);
  assign space_ok  = (cnt_after < CW'(DEPTH));

  assign mem_req_o  = (state_q == REQ) || (state_q == DRAIN);
  assign mem_addr_o = addr_q;
  assign count_o    = count_q;

  // -------------------------------------------------------------------------
  // Fetch FSM
  // -------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    addr_d     = addr_q;

    unique case (state_q)
      IDLE: begin
        if (redirect_i) begin
          // FIFO is flushed this cycle, so there is always room to restart
          // immediately at the target.
          fetch_pc_d = redirect_pc_i;
          if (start_i) begin
            state_d = REQ;
            addr_d  = redirect_pc_i;
          end
        end else if (start_i && space_ok) begin
          state_d = REQ;
          addr_d  = fetch_pc_q;
        end
      end

      REQ: begin
        if (mem_ack_i) begin
          if (redirect_i) begin
            fetch_pc_d = redirect_pc_i;
            state_d    = IDLE;
          end else begin
            fetch_pc_d = fetch_pc_q + PC_INC;
            if (start_i && space_ok) begin
              addr_d = fetch_pc_q + PC_INC;
            end else begin
              state_d = IDLE;
            end
          end
        end else if (redirect_i) begin
          // Request cannot be withdrawn; wait for its response and drop it.
          fetch_pc_d = redirect_pc_i;
          state_d    = DRAIN;
        end
      end

      DRAIN: begin
        if (redirect_i) begin
          fetch_pc_d = redirect_pc_i;
        end
        if (mem_ack_i) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      addr_q     <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
    end
  end

  // -------------------------------------------------------------------------
  // FIFO pointers and occupancy; redirect overrides any push/pop
  // -------------------------------------------------------------------------
  always_comb begin
    count_d  = cnt_after;
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    if (redirect_i) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is reset so the head outputs read zero out of reset.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        pc_mem_q[i]    <= '0;
        instr_mem_q[i] <= '0;
      end
    end else if (push) begin
      pc_mem_q[wr_ptr_q]    <= fetch_pc_q;
      instr_mem_q[wr_ptr_q] <= mem_rdata_i;
    end
  end

`ifndef SYNTHESIS
  a_no_overflow : assert property (@(posedge clk_i) disable iff (!rst_i)
    push |-> (count_q < CW'(DEPTH)));

  a_req_stable : assert property (@(posedge clk_i) disable iff (!rst_i)
    (mem_req_o && !mem_ack_i) |=> (mem_req_o && $stable(mem_addr_o)));
`endif

endmodule

// File: tb/tb_instr_prefetch_queue.sv
`timescale 1ns/1ps
module tb_instr_prefetch_queue;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic        instr_ready_i;
  logic [2:0]  count_o;

  int n_checks = 0;
  int n_errors = 0;

  // memory model controls
  int   mem_lat  = 0;
  logic mem_hold = 1'b0;
  int   wcnt     = 0;

  logic [31:0] exp_q[$];

  instr_prefetch_queue #(.DEPTH(4), .INSTR_LEN(4), .RESET_PC(32'h0)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .start_i       (start_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .mem_req_o     (mem_req_o),
    .mem_addr_o    (mem_addr_o),
    .mem_ack_i     (mem_ack_i),
    .mem_rdata_i   (mem_rdata_i),
    .instr_valid_o (instr_valid_o),
    .instr_o       (instr_o),
    .pc_o          (pc_o),
    .instr_ready_i (instr_ready_i),
    .count_o       (count_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] word_of(logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Memory responder: acks after mem_lat waiting cycles unless held.
  initial begin
    mem_ack_i   = 1'b0;
    mem_rdata_i = '0;
    forever begin
      @(posedge clk_i);
      #1;
      if (mem_req_o && !mem_hold) begin
        if (wcnt >= mem_lat) begin
          mem_ack_i   = 1'b1;
          mem_rdata_i = word_of(mem_addr_o);
          wcnt        = 0;
        end else begin
          mem_ack_i = 1'b0;
          wcnt++;
        end
      end else begin
        mem_ack_i = 1'b0;
        if (!mem_req_o) wcnt = 0;
      end
    end
  end

  // Scoreboard: every instruction IF consumes must be the next expected PC.
  always @(negedge clk_i) begin : sb_mon
    logic [31:0] ep;
    if (rst_i && instr_valid_o && instr_ready_i) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL sb_extra: got pc %h, expected no delivery", pc_o);
      end else begin
        ep = exp_q.pop_front();
        chk("sb_pc", pc_o, ep);
        chk("sb_instr", instr_o, word_of(ep));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    rst_i         = 1'b0;
    start_i       = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = '0;
    instr_ready_i = 1'b0;
    mem_hold      = 1'b0;
    mem_lat       = 0;
    exp_q.delete();
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_req", 32'(mem_req_o), 0);
    chk("rst_addr", mem_addr_o, 32'h0);
    chk("rst_valid", 32'(instr_valid_o), 0);
    chk("rst_cnt", 32'(count_o), 0);
    @(negedge clk_i);
    rst_i = 1'b1;
    step();
  endtask

  task automatic drain(string name);
    instr_ready_i = 1'b1;
    start_i       = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (count_o == 0 && exp_q.size() == 0 && !mem_req_o) break;
    end
    chk({name, "_cnt"}, 32'(count_o), 0);
    chk({name, "_left"}, 32'(exp_q.size()), 0);
    instr_ready_i = 1'b0;
  endtask

  typedef struct {
    logic        start;
    logic        ready;
    logic        req;
    logic [31:0] addr;
    logic [2:0]  cnt;
    logic        valid;
    logic [31:0] pc;
  } vec_t;

  vec_t tbl[13];

  initial begin
    // Backpressure fill with zero-wait memory: inputs for one cycle and the
    // outputs expected right after the following clock edge.
    tbl[0]  = '{1'b1, 1'b0, 1'b1, 32'h00, 3'd0, 1'b0, 32'h00};
    tbl[1]  = '{1'b1, 1'b0, 1'b1, 32'h04, 3'd1, 1'b1, 32'h00};
    tbl[2]  = '{1'b1, 1'b0, 1'b1, 32'h08, 3'd2, 1'b1, 32'h00};
    tbl[3]  = '{1'b1, 1'b0, 1'b1, 32'h0C, 3'd3, 1'b1, 32'h00};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 32'h0C, 3'd4, 1'b1, 32'h00};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 32'h0C, 3'd4, 1'b1, 32'h00};
    tbl[6]  = '{1'b1, 1'b1, 1'b1, 32'h10, 3'd3, 1'b1, 32'h04};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 32'h10, 3'd4, 1'b1, 32'h04};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 32'h10, 3'd4, 1'b1, 32'h04};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 32'h10, 3'd3, 1'b1, 32'h08};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 32'h10, 3'd2, 1'b1, 32'h0C};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 32'h10, 3'd1, 1'b1, 32'h10};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 32'h10, 3'd0, 1'b0, 32'h00};

    // ---- streaming, zero-wait, IF always ready ----
    do_reset();
    for (int k = 0; k < 8; k++) exp_q.push_back(32'(4 * k));
    start_i       = 1'b1;
    instr_ready_i = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      chk("str_req", 32'(mem_req_o), 1);
      chk("str_addr", mem_addr_o, 32'(4 * (k - 1)));
      if (k >= 2) chk("str_cnt", 32'(count_o), 1);
    end
    start_i = 1'b0;
    step();
    chk("str_stop_req", 32'(mem_req_o), 0);
    chk("str_last_pc", pc_o, 32'h1C);
    drain("str");

    // ---- backpressure fill, table-driven ----
    do_reset();
    exp_q.push_back(32'h00);
    exp_q.push_back(32'h04);
    exp_q.push_back(32'h08);
    exp_q.push_back(32'h0C);
    exp_q.push_back(32'h10);
    for (int i = 0; i < 13; i++) begin
      start_i       = tbl[i].start;
      instr_ready_i = tbl[i].ready;
      step();
      chk("tbl_req", 32'(mem_req_o), 32'(tbl[i].req));
      chk("tbl_addr", mem_addr_o, tbl[i].addr);
      chk("tbl_cnt", 32'(count_o), 32'(tbl[i].cnt));
      chk("tbl_valid", 32'(instr_valid_o), 32'(tbl[i].valid));
      if (tbl[i].valid) chk("tbl_pc", pc_o, tbl[i].pc);
    end
    drain("tbl");

    // ---- 3-cycle ack delay ----
    do_reset();
    mem_lat = 3;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    start_i       = 1'b1;
    instr_ready_i = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      chk("lat_req", 32'(mem_req_o), 1);
      chk("lat_addr", mem_addr_o, (k <= 4) ? 32'h0 : 32'h4);
      chk("lat_valid", 32'(instr_valid_o), (k == 5) ? 32'd1 : 32'd0);
    end
    start_i = 1'b0;
    step();
    chk("lat_stop_req", 32'(mem_req_o), 0);
    chk("lat_pc4", pc_o, 32'h4);
    drain("lat");

    // ---- redirect while a request is pending (DRAIN) ----
    do_reset();
    exp_q.push_back(32'h40);
    start_i = 1'b1;
    step();
    chk("drn_a0", mem_addr_o, 32'h0);
    step();
    chk("drn_a4", mem_addr_o, 32'h4);
    @(negedge clk_i);
    mem_hold = 1'b1;
    step();
    chk("drn_a8", mem_addr_o, 32'h8);
    chk("drn_cnt2", 32'(count_o), 2);
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h40;
    step();
    redirect_i = 1'b0;
    chk("drn_flush_cnt", 32'(count_o), 0);
    chk("drn_flush_valid", 32'(instr_valid_o), 0);
    chk("drn_hold_req", 32'(mem_req_o), 1);
    chk("drn_hold_addr", mem_addr_o, 32'h8);
    step();
    chk("drn_hold_addr2", mem_addr_o, 32'h8);
    @(negedge clk_i);
    mem_hold = 1'b0;
    step();
    chk("drn_ack_addr", mem_addr_o, 32'h8);
    step();
    chk("drn_idle_req", 32'(mem_req_o), 0);
    chk("drn_discard_cnt", 32'(count_o), 0);
    step();
    chk("drn_new_req", 32'(mem_req_o), 1);
    chk("drn_new_addr", mem_addr_o, 32'h40);
    start_i = 1'b0;
    step();
    chk("drn_cnt1", 32'(count_o), 1);
    chk("drn_pc40", pc_o, 32'h40);
    drain("drn");

    // ---- redirect with same-cycle ack, then double redirect in DRAIN ----
    do_reset();
    exp_q.push_back(32'h80);
    start_i = 1'b1;
    step();
    chk("dbl_a0", mem_addr_o, 32'h0);
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h60;
    @(negedge clk_i);
    mem_hold = 1'b1;
    step();
    redirect_i = 1'b0;
    chk("dbl_same_req", 32'(mem_req_o), 0);
    chk("dbl_same_cnt", 32'(count_o), 0);
    step();
    chk("dbl_req60", mem_addr_o, 32'h60);
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h70;
    step();
    chk("dbl_drain_addr", mem_addr_o, 32'h60);
    redirect_pc_i = 32'h80;
    step();
    redirect_i = 1'b0;
    chk("dbl_drain_req", 32'(mem_req_o), 1);
    @(negedge clk_i);
    mem_hold = 1'b0;
    step();
    chk("dbl_ack_addr", mem_addr_o, 32'h60);
    step();
    chk("dbl_idle_cnt", 32'(count_o), 0);
    step();
    chk("dbl_req80", mem_addr_o, 32'h80);
    chk("dbl_req80_v", 32'(mem_req_o), 1);
    start_i = 1'b0;
    step();
    chk("dbl_pc80", pc_o, 32'h80);
    drain("dbl");

    // ---- reset mid-request with two entries buffered ----
    do_reset();
    start_i = 1'b1;
    step();
    step();
    @(negedge clk_i);
    mem_hold = 1'b1;
    step();
    chk("mid_cnt2", 32'(count_o), 2);
    chk("mid_addr8", mem_addr_o, 32'h8);
    rst_i = 1'b0;
    #1;
    chk("mid_rst_req", 32'(mem_req_o), 0);
    chk("mid_rst_addr", mem_addr_o, 32'h0);
    chk("mid_rst_valid", 32'(instr_valid_o), 0);
    chk("mid_rst_cnt", 32'(count_o), 0);
    chk("mid_rst_instr", instr_o, 32'h0);
    chk("mid_rst_pc", pc_o, 32'h0);
    @(negedge clk_i);
    rst_i    = 1'b1;
    mem_hold = 1'b0;
    exp_q.push_back(32'h0);
    step();
    chk("mid_restart_req", 32'(mem_req_o), 1);
    chk("mid_restart_addr", mem_addr_o, 32'h0);
    start_i = 1'b0;
    step();
    chk("mid_restart_pc", pc_o, 32'h0);
    drain("mid");

    // ---- redirect from IDLE: latency and 32-bit PC wrap ----
    do_reset();
    exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h0);
    redirect_i    = 1'b1;
    redirect_pc_i = 32'hFFFF_FFFC;
    start_i       = 1'b1;
    step();
    redirect_i = 1'b0;
    chk("wrap_req", 32'(mem_req_o), 1);
    chk("wrap_addr", mem_addr_o, 32'hFFFF_FFFC);
    step();
    start_i = 1'b0;
    chk("wrap_valid", 32'(instr_valid_o), 1);
    chk("wrap_pc", pc_o, 32'hFFFF_FFFC);
    chk("wrap_addr0", mem_addr_o, 32'h0);
    step();
    chk("wrap_cnt2", 32'(count_o), 2);
    drain("wrap");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
